// File: rtl/div32x32_pkg.sv
// div32x32_pkg: shared state encoding and sizing for the iterative divider.
package div32x32_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;
endpackage

// File: rtl/div32x32_fsm.sv
// div32x32_fsm: sequencing for the divider; owns state, iteration count, busy and done.
module div32x32_fsm
    import div32x32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic load_o,
    output logic step_o,
    output logic commit_o
);
    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    assign load_o   = (state_q == IDLE) && start_i;
    assign step_o   = (state_q == CALC);
    assign commit_o = (state_q == DONE);
    assign busy_o   = busy_q;
    assign done_o   = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= CALC;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/div32x32.sv
// div32x32: unsigned radix-2 restoring divider, one quotient bit per clock.
// A zero divisor never borrows, so it naturally yields all-ones quotient and remainder = a.
module div32x32
    import div32x32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    logic             load, step, commit;
    logic [WIDTH-1:0] rem_q, rem_d, qsr_q, qsr_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d, rmd_q, rmd_d;
    logic             zero_q, zero_d, dbz_q, dbz_d;
    logic [WIDTH:0]   shifted, trial;

    div32x32_fsm #(.WIDTH(WIDTH), .CNT_W($clog2(WIDTH) + 1)) u_fsm (
        .clk_i    (clk),
        .rst_ni   (reset),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .load_o   (load),
        .step_o   (step),
        .commit_o (commit)
    );

    // trial[WIDTH] is the borrow: set exactly when the shifted remainder is below the divisor
    always_comb begin
        shifted = {rem_q, qsr_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        rem_d   = load ? '0 : step ? (trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0]) : rem_q;
        qsr_d   = load ? a : step ? {qsr_q[WIDTH-2:0], ~trial[WIDTH]} : qsr_q;
        dvs_d   = load ? b : dvs_q;
        zero_d  = load ? (b == '0) : zero_q;
        quot_d  = commit ? qsr_q : quot_q;
        rmd_d   = commit ? rem_q : rmd_q;
        dbz_d   = commit ? zero_q : dbz_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q  <= '0;
            qsr_q  <= '0;
            dvs_q  <= '0;
            zero_q <= 1'b0;
            quot_q <= '0;
            rmd_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            qsr_q  <= qsr_d;
            dvs_q  <= dvs_d;
            zero_q <= zero_d;
            quot_q <= quot_d;
            rmd_q  <= rmd_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div32x32.sv
// tb_div32x32: directed and random checks of div32x32 against plain-arithmetic expectations.
module tb_div32x32;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
    int          total = 0, bad = 0, dones = 0;

    div32x32 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (done) dones++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the next rising edge.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit poke);
        int          cyc, bc, held;
        logic [31:0] pq, pr, eq, er;
        logic        pz;
        eq = (y == 0) ? 32'hFFFF_FFFF : x / y;
        er = (y == 0) ? x : x % y;
        pq = quotient; pr = remainder; pz = div_by_zero;
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; bc = busy ? 1 : 0; held = 0;
        while (!done && cyc < 100) begin
            if (quotient !== pq || remainder !== pr || div_by_zero !== pz) held++;
            @(negedge clk);
            cyc++;
            if (busy) bc++;
            if (poke && cyc == 10) begin a = 9; b = 3; start = 1'b1; end
            if (poke && cyc == 11) begin start = 1'b0; a = $urandom; b = $urandom; end
        end
        chk("latency", cyc, 33);
        chk("busy_cycles", bc, 33);
        chk("held_in_calc", held, 0);
        chk("done", {31'b0, done}, 1);
        chk("busy_at_done", {31'b0, busy}, 0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, y == 0});
    endtask

    task automatic op_pulse(input logic [31:0] x, input logic [31:0] y);
        do_op(x, y, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 0);
    endtask

    initial begin
        int d0;
        logic [31:0] x, y;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_dbz", {31'b0, div_by_zero}, 0);
        reset = 1'b1;
        op_pulse(100, 7);
        op_pulse(32'hFFFF_FFFF, 1);
        op_pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op_pulse(3, 10);
        op_pulse(32'h1234_5678, 0);
        do_op(50, 6, 1'b1);
        @(negedge clk);
        a = 1000; b = 10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_done", {31'b0, done}, 0);
        chk("arst_quot", quotient, 0);
        chk("arst_rem", remainder, 0);
        chk("arst_dbz", {31'b0, div_by_zero}, 0);
        d0 = dones;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("arst_no_done", dones - d0, 0);
        op_pulse(81, 9);
        chk("arst_one_done", dones - d0, 1);
        d0 = dones;
        do_op(17, 5, 1'b0);
        do_op(40, 8, 1'b0);
        @(negedge clk);
        chk("b2b_dones", dones - d0, 2);
        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = $urandom;
                1: y = $urandom_range(1, 255);
                2: y = x >> $urandom_range(0, 31);
                default: y = (i % 7 == 0) ? 32'd0 : 32'(i + 1);
            endcase
            op_pulse(x, y);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div32x32.md
Name: div32x32

Overview:
- Iterative unsigned radix-2 restoring divider; the inverse-operation companion to the 32x32 iterative multiplier.
- Uses the same start/busy handshake, so the calculator datapath can drive either unit identically.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits (even, ≥ 4).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  dividend; sampled on the accepting edge only.
- b  input  WIDTH  divisor; sampled on the accepting edge only.
- busy  output  1  divider occupied; start ignored while high.
- done  output  1  one-cycle pulse; results updated this cycle.
- div_by_zero  output  1  last completed operation had b==0; held with results.
- quotient  output  WIDTH  last completed quotient.
- remainder  output  WIDTH  last completed remainder.

Behaviour:
- Reset (reset=0): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0. Internal registers (iteration counter, working remainder, dividend shift register, divisor copy) are cleared.
- Reset mid-operation: the operation is aborted and no done pulse is generated. After reset is released, the unit sits in IDLE and accepts start on the first rising edge.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge E0:
  - latch a into the dividend shift register (q_sr) and b into the divisor register;
  - clear the working remainder (WIDTH+1 bits) and the counter; record zero-divisor flag = (b==0);
  - go to CALC; busy=1 from E0.
- IDLE, start=0: stay in IDLE; outputs hold their values.
- CALC, one iteration per edge, WIDTH iterations total (E1..E_WIDTH):
  - {rem, q_sr} shift left by 1;
  - trial = rem_shifted − {1'b0, divisor};
  - if trial does not borrow: rem = trial and q_sr[0] = 1; otherwise keep rem_shifted and set q_sr[0] = 0;
  - counter increments; after the WIDTH-th iteration, go to DONE.
- DONE, edge E_WIDTH+1:
  - quotient = q_sr; remainder = rem[WIDTH-1:0]; div_by_zero = zero-divisor flag;
  - done=1 for exactly this cycle; busy=0 at the same edge; state returns to IDLE.
- Latency: start accepted at E0 → results and done visible after E_{WIDTH+1}, i.e. 33 clocks for WIDTH=32. Busy is high for exactly WIDTH+1 cycles.
- Divide by zero: the unit still takes the full, fixed latency. Forced results: quotient = all ones, remainder = a, div_by_zero = 1.
- Outputs quotient, remainder and div_by_zero are separate registers. They change only in DONE or on reset, and hold their previous values throughout CALC.
- start while busy=1: ignored, with no queuing. Changes on a/b after the accepting edge have no effect.
- Back-to-back operation: start asserted in the cycle after done is accepted. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic: the working remainder is WIDTH+1 bits wide to hold the borrow. The counter is $clog2(WIDTH)+1 bits wide. All values are unsigned; there is no signed mode.

Decomposition:
- Package div32x32_pkg holds:
  - state enum typedef div_state_t {IDLE, CALC, DONE};
  - localparam DIV_CNT_W.
- Natural split mirrors the multiplier's control/arith division:
  - sub-module div32x32_fsm owns the state register, counter, busy and done;
  - it drives load, step and commit strobes into the datapath in div32x32.

Test Plan:
- a=100, b=7, start pulse: busy=1 for 33 cycles → done pulse; quotient=14, remainder=2, div_by_zero=0.
- a=0xFFFFFFFF, b=1 → quotient=0xFFFFFFFF, remainder=0. Then a=0xFFFFFFFF, b=0xFFFFFFFF → quotient=1, remainder=0.
- a=3, b=10 → quotient=0, remainder=3. Then a=0x12345678, b=0 → quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, still 33-cycle latency.
- Start 50/6. At cycle 10, pulse start with a=9, b=3 and change a/b → second start ignored; result quotient=8, remainder=2; the first-operation outputs were held unchanged during CALC.
- Start 1000/10, then assert reset=0 asynchronously mid-CALC (between edges) → busy=0 and all outputs 0 immediately, with no done pulse. Release reset, start 81/9 → quotient=9, remainder=0 after 33 cycles.
- Back-to-back: issue 17/5 and 40/8 with minimum spacing (second start the cycle after done) → results 3 r2, then 5 r0; exactly two done pulses.
